// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, one-entry skid buffer.
// Optional IF_MISALIGN_CHK_EN: misaligned redirect targets halt fetch.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hold_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        misalign_o
);

`ifdef IF_MISALIGN_CHK_EN
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
`endif

    state_t      state;
    state_t      halt_st;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] next_pc;
    logic [31:0] redir_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        skid_v;
    logic        ack;
    logic        fetch_ack;
    logic        bad;
    logic        halt_pend;

`ifdef IF_MISALIGN_CHK_EN
    logic mis_q;

    assign redir_pc   = redirect_pc_i;
    assign bad        = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign halt_st    = HALT;
    assign halt_pend  = mis_q | bad;
    assign misalign_o = mis_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mis_q <= 1'b0;
        end else if (bad) begin
            mis_q <= 1'b1;
        end
    end
`else
    assign redir_pc   = redirect_pc_i & 32'hFFFF_FFFC;
    assign bad        = 1'b0;
    assign halt_st    = FETCH;
    assign halt_pend  = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // DRAIN keeps the abandoned request visible until memory answers it
    assign imem_req_o  = ((state == FETCH) && !skid_v) || (state == DRAIN);
    assign imem_addr_o = req_addr;
    assign ack         = imem_req_o & imem_ack_i;
    assign fetch_ack   = ack && (state == FETCH);
    assign next_pc     = req_addr + 32'd4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            skid_v     <= 1'b0;
            skid_pc    <= 32'd0;
            skid_instr <= 32'd0;
            pc_o       <= 32'd0;
            instr_o    <= 32'd0;
            valid_o    <= 1'b0;
        end else begin
            if (redirect_i) begin
                valid_o <= 1'b0;
                skid_v  <= 1'b0;
            end else if (hold_i) begin
                if (fetch_ack) begin
                    skid_pc    <= req_addr;
                    skid_instr <= imem_rdata_i;
                    skid_v     <= 1'b1;
                end
            end else if (skid_v) begin
                pc_o    <= skid_pc;
                instr_o <= skid_instr;
                valid_o <= 1'b1;
                skid_v  <= 1'b0;
            end else if (fetch_ack) begin
                pc_o    <= req_addr;
                instr_o <= imem_rdata_i;
                valid_o <= 1'b1;
            end else begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc <= redir_pc;
                        req_addr <= redir_pc;
                        if (bad) state <= halt_st;
                    end else if (start_i) begin
                        req_addr <= fetch_pc;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect_i) begin
                        fetch_pc <= redir_pc;
                        if (imem_req_o && !imem_ack_i) begin
                            state <= DRAIN;
                        end else begin
                            req_addr <= redir_pc;
                            if (bad) state <= halt_st;
                        end
                    end else if (ack) begin
                        fetch_pc <= next_pc;
                        req_addr <= next_pc;
                    end
                end
                DRAIN: begin
                    if (redirect_i) fetch_pc <= redir_pc;
                    if (imem_ack_i) begin
                        req_addr <= redirect_i ? redir_pc : fetch_pc;
                        state    <= halt_pend ? halt_st : FETCH;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a latency-programmable imem responder.
module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        misalign_o;

    int total = 0;
    int fails = 0;
    int lat = 0;
    int cnt = 0;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .hold_i(hold_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i),
        .pc_o(pc_o),
        .instr_o(instr_o),
        .valid_o(valid_o),
        .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // memory: answers after 'lat' wait cycles, instr = addr + 0x1000_0000
    always @(negedge clk_i) begin
        if (imem_req_o && rst_i) begin
            if (cnt >= lat) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = imem_addr_o + 32'h1000_0000;
                cnt          = 0;
            end else begin
                imem_ack_i = 1'b0;
                cnt        = cnt + 1;
            end
        end else begin
            imem_ack_i = 1'b0;
            cnt        = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1 rst_i = 1'b0;
        #10;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_mis", {31'd0, misalign_o}, 32'd0);
        #1;
        rst_i   = 1'b1;
        start_i = 1'b1;

        tick();
        check("f0_req", {31'd0, imem_req_o}, 32'd1);
        check("f0_addr", imem_addr_o, 32'h0);
        check("f0_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("seq_pc0", pc_o, 32'h0);
        check("seq_in0", instr_o, 32'h1000_0000);
        check("seq_v0", {31'd0, valid_o}, 32'd1);
        tick();
        start_i = 1'b0;
        check("seq_pc4", pc_o, 32'h4);
        tick();
        check("seq_pc8", pc_o, 32'h8);
        check("seq_v8", {31'd0, valid_o}, 32'd1);
        tick();
        check("seq_pcC", pc_o, 32'hC);

        lat = 3;
        tick();
        check("dr_pre_addr", imem_addr_o, 32'h10);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        check("dr_req", {31'd0, imem_req_o}, 32'd1);
        check("dr_addr", imem_addr_o, 32'h10);
        check("dr_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("dr_addr2", imem_addr_o, 32'h10);
        check("dr_valid2", {31'd0, valid_o}, 32'd0);
        tick();
        check("dr_done_v", {31'd0, valid_o}, 32'd0);
        check("dr_new_addr", imem_addr_o, 32'h100);
        lat = 0;
        tick();
        check("dr_pc", pc_o, 32'h100);
        check("dr_instr", instr_o, 32'h1000_0100);
        check("dr_v", {31'd0, valid_o}, 32'd1);

        lat = 2;
        tick();
        check("lat_v0", {31'd0, valid_o}, 32'd0);
        check("lat_addr0", imem_addr_o, 32'h104);
        tick();
        check("lat_v1", {31'd0, valid_o}, 32'd0);
        check("lat_addr1", imem_addr_o, 32'h104);
        check("lat_req1", {31'd0, imem_req_o}, 32'd1);
        tick();
        check("lat_v2", {31'd0, valid_o}, 32'd1);
        check("lat_pc", pc_o, 32'h104);
        lat    = 0;
        hold_i = 1'b1;

        tick();
        check("hold_req", {31'd0, imem_req_o}, 32'd0);
        check("hold_pc", pc_o, 32'h104);
        check("hold_v", {31'd0, valid_o}, 32'd1);
        tick();
        check("hold_req2", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("hold_pc3", pc_o, 32'h104);
        hold_i = 1'b0;
        tick();
        check("skid_pc", pc_o, 32'h108);
        check("skid_instr", instr_o, 32'h1000_0108);
        check("skid_v", {31'd0, valid_o}, 32'd1);
        check("skid_next", imem_addr_o, 32'h10C);
        check("skid_req", {31'd0, imem_req_o}, 32'd1);

        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        check("wr_v", {31'd0, valid_o}, 32'd0);
        check("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        check("wr_pc", pc_o, 32'hFFFF_FFFC);
        check("wr_next", imem_addr_o, 32'h0);

        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
        check("mis_v", {31'd0, valid_o}, 32'd0);
`ifdef IF_MISALIGN_CHK_EN
        check("mis_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("mis_req2", {31'd0, imem_req_o}, 32'd0);
        check("mis_flag2", {31'd0, misalign_o}, 32'd1);
`else
        check("mis_flag", {31'd0, misalign_o}, 32'd0);
        check("mis_addr", imem_addr_o, 32'h100);
        check("mis_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        check("mis_pc", pc_o, 32'h100);
        check("mis_vf", {31'd0, valid_o}, 32'd1);
`endif

        #3 rst_i = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_req_o}, 32'd0);
        check("arst_v", {31'd0, valid_o}, 32'd0);
        check("arst_pc", pc_o, 32'd0);
        check("arst_mis", {31'd0, misalign_o}, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
